// File: rtl/writeback_buffer.sv
// Write-back (victim) buffer: queues dirty evicted cache lines in FIFO order,
// drains them to memory one line at a time, and lets a pending miss pick up a
// queued victim through a combinational lookup port.
module writeback_buffer #(
    parameter int DEPTH           = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int CACHE_LINE_SIZE = 256,
    parameter int OFFSET_BITS     = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push_valid,
    output logic                                push_ready,
    input  logic [ADDR_WIDTH-OFFSET_BITS-1:0]   push_line_addr,
    input  logic [CACHE_LINE_SIZE-1:0]          push_data,
    input  logic                                lookup_valid,
    input  logic [ADDR_WIDTH-OFFSET_BITS-1:0]   lookup_line_addr,
    output logic                                lookup_hit,
    output logic [CACHE_LINE_SIZE-1:0]          lookup_data,
    output logic                                mem_write,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic [CACHE_LINE_SIZE-1:0]          mem_wdata,
    input  logic                                mem_resp,
    output logic                                empty,
    output logic                                full,
    output logic [$clog2(DEPTH+1)-1:0]          count
);

    localparam int LA = ADDR_WIDTH - OFFSET_BITS;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                     state_q;
    logic                       mem_write_q;
    logic [PW-1:0]              head_q;
    logic [PW-1:0]              tail_q;
    logic [CW-1:0]              count_q;
    logic [CW-1:0]              count_d;
    logic [DEPTH-1:0]           valid_q;
    logic [LA-1:0]              addr_q [DEPTH];
    logic [CACHE_LINE_SIZE-1:0] data_q [DEPTH];

    logic                       push_acc_s;
    logic                       pop_s;
    logic                       full_s;
    logic [PW-1:0]              lookup_idx_s;
    logic                       lookup_hit_s;
    logic [CACHE_LINE_SIZE-1:0] lookup_data_s;

    // Flags come straight from the registered count; a full buffer refuses
    // pushes even when the head pops in the same cycle.
    assign full_s     = (count_q == CW'(DEPTH));
    assign full       = full_s;
    assign empty      = (count_q == {CW{1'b0}});
    assign count      = count_q;
    assign push_ready = !full_s;
    assign push_acc_s = push_valid && !full_s;
    // mem_resp only has meaning while a write is outstanding.
    assign pop_s      = (state_q == S_WRITE) && mem_resp;

    // Occupancy next-state: simultaneous push and pop leaves count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_acc_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, count and per-entry valid bits; reset drops all contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            valid_q <= {DEPTH{1'b0}};
        end else begin
            count_q <= count_d;
            // Head and tail never coincide when both fire (buffer neither
            // empty nor full), so clearing and setting valid cannot collide.
            if (pop_s) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end else begin
                head_q <= head_q;
            end
            if (push_acc_s) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PW'(1);
            end else begin
                tail_q <= tail_q;
            end
        end
    end

    // Entry payload storage; only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            addr_q[tail_q] <= push_line_addr;
            data_q[tail_q] <= push_data;
        end else begin
            addr_q[tail_q] <= addr_q[tail_q];
            data_q[tail_q] <= data_q[tail_q];
        end
    end

    // Drain FSM: one write in flight, then a single idle cycle before the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_write_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != {CW{1'b0}}) begin
                        state_q     <= S_WRITE;
                        mem_write_q <= 1'b1;
                    end else begin
                        state_q     <= S_IDLE;
                        mem_write_q <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (mem_resp) begin
                        state_q     <= S_GAP;
                        mem_write_q <= 1'b0;
                    end else begin
                        state_q     <= S_WRITE;
                        mem_write_q <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (count_q != {CW{1'b0}}) begin
                        state_q     <= S_WRITE;
                        mem_write_q <= 1'b1;
                    end else begin
                        state_q     <= S_IDLE;
                        mem_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // The head entry cannot be overwritten while a write is outstanding, so
    // address and data stay stable until mem_resp.
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_write_q ? {addr_q[head_q], {OFFSET_BITS{1'b0}}}
                                   : {ADDR_WIDTH{1'b0}};
    assign mem_wdata = mem_write_q ? data_q[head_q] : {CACHE_LINE_SIZE{1'b0}};

    // Lookup walks oldest to youngest so the youngest matching entry wins.
    always_comb begin
        lookup_hit_s  = 1'b0;
        lookup_data_s = {CACHE_LINE_SIZE{1'b0}};
        lookup_idx_s  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            lookup_idx_s = head_q + PW'(i);
            if (lookup_valid && valid_q[lookup_idx_s] &&
                (addr_q[lookup_idx_s] == lookup_line_addr)) begin
                lookup_hit_s  = 1'b1;
                lookup_data_s = data_q[lookup_idx_s];
            end else begin
                lookup_hit_s  = lookup_hit_s;
                lookup_data_s = lookup_data_s;
            end
        end
    end

    assign lookup_hit  = lookup_hit_s;
    assign lookup_data = lookup_data_s;

endmodule

// File: tb/tb_writeback_buffer.sv
// Scoreboard bench for writeback_buffer: accepted pushes enqueue the expected
// memory write; a monitor compares each completed memory write against it.
module tb_writeback_buffer;

    localparam int LA = 27;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid;
    logic          push_ready;
    logic [LA-1:0] push_line_addr;
    logic [255:0]  push_data;
    logic          lookup_valid;
    logic [LA-1:0] lookup_line_addr;
    logic          lookup_hit;
    logic [255:0]  lookup_data;
    logic          mem_write;
    logic [31:0]   mem_addr;
    logic [255:0]  mem_wdata;
    logic          mem_resp;
    logic          empty;
    logic          full;
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0]  addr;
        logic [255:0] data;
    } wr_t;
    wr_t exp_q[$];

    writeback_buffer #(
        .DEPTH(4), .ADDR_WIDTH(32), .CACHE_LINE_SIZE(256), .OFFSET_BITS(5)
    ) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_line_addr(push_line_addr), .push_data(push_data),
        .lookup_valid(lookup_valid), .lookup_line_addr(lookup_line_addr),
        .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp),
        .empty(empty), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mk(input logic [31:0] w);
        return {8{w}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed memory write must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && mem_write && mem_resp) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mem_unexpected: got addr %0h, no write expected", mem_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL mem_write: got addr %0h data %0h expected addr %0h data %0h",
                             mem_addr, mem_wdata[31:0], e.addr, e.data[31:0]);
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic push(input logic [LA-1:0] a, input logic [255:0] d);
        bit ok;
        ok = 1'b0;
        push_valid = 1'b1; push_line_addr = a; push_data = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (push_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL push_timeout: got push_ready 0 expected 1");
        end
        @(posedge clk); #1;
        push_valid = 1'b0;
        if (ok) exp_q.push_back({a, 5'd0, d});
    endtask

    task automatic wait_write();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_write) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL write_timeout: got mem_write 0 expected 1");
        end
    endtask

    // One-cycle memory completion for the current write.
    task automatic ack();
        wait_write();
        @(posedge clk); #1; mem_resp = 1'b1;
        @(posedge clk); #1; mem_resp = 1'b0;
    endtask

    initial begin
        rst = 1'b1; push_valid = 1'b0; push_line_addr = '0; push_data = '0;
        lookup_valid = 1'b1; lookup_line_addr = '0; mem_resp = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", 256'(count), 256'd0);
        chk("rst_empty", 256'(empty), 256'd1);
        chk("rst_full", 256'(full), 256'd0);
        chk("rst_mem_write", 256'(mem_write), 256'd0);
        chk("rst_push_ready", 256'(push_ready), 256'd1);
        chk("rst_lookup_hit", 256'(lookup_hit), 256'd0);
        rst = 1'b0;
        lookup_valid = 1'b0;
        @(posedge clk); #1;

        // 1: single line, latency, stability while mem_resp is held low
        push(27'h1234, mk(32'hD0D0_0000));
        @(negedge clk);
        chk("t1_count", 256'(count), 256'd1);
        chk("t1_no_write_yet", 256'(mem_write), 256'd0);
        @(negedge clk);
        chk("t1_mem_write", 256'(mem_write), 256'd1);
        chk("t1_mem_addr", 256'(mem_addr), 256'h0002_4680);
        chk("t1_mem_wdata", mem_wdata, mk(32'hD0D0_0000));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t1_hold_addr", 256'(mem_addr), 256'h0002_4680);
            chk("t1_hold_write", 256'(mem_write), 256'd1);
        end
        ack();
        @(negedge clk);
        chk("t1_write_drop", 256'(mem_write), 256'd0);
        chk("t1_empty", 256'(empty), 256'd1);
        chk("t1_gap_addr", 256'(mem_addr), 256'd0);
        repeat (3) @(posedge clk); #1;

        // 2: fill to full, 5th push stalls until one drain, order and wrap
        push(27'h10, mk(32'hA0));
        push(27'h11, mk(32'hA1));
        push(27'h12, mk(32'hA2));
        push(27'h13, mk(32'hA3));
        @(negedge clk);
        chk("t2_full", 256'(full), 256'd1);
        chk("t2_push_ready", 256'(push_ready), 256'd0);
        chk("t2_count", 256'(count), 256'd4);
        @(posedge clk); #1;
        fork
            push(27'h14, mk(32'hA4));
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("t2_stall_count", 256'(count), 256'd4);
                    chk("t2_stall_ready", 256'(push_ready), 256'd0);
                end
                ack();
                @(negedge clk);
                chk("t2_ready_after_pop", 256'(push_ready), 256'd1);
            end
        join
        @(negedge clk);
        chk("t2_refilled", 256'(count), 256'd4);
        @(posedge clk); #1;
        repeat (4) ack();
        repeat (3) @(negedge clk);
        chk("t2_drained", 256'(empty), 256'd1);
        @(posedge clk); #1;

        // 3: lookup hits, misses, youngest duplicate, same-cycle push invisible
        push(27'h100, mk(32'hDA));
        push(27'h200, mk(32'hDB));
        lookup_valid = 1'b1; lookup_line_addr = 27'h200;
        @(negedge clk);
        chk("t3_hit_b", 256'(lookup_hit), 256'd1);
        chk("t3_data_b", lookup_data, mk(32'hDB));
        lookup_line_addr = 27'h300;
        #1;
        chk("t3_miss_c", 256'(lookup_hit), 256'd0);
        chk("t3_miss_data", lookup_data, 256'd0);
        @(posedge clk); #1;
        push(27'h100, mk(32'hD2));
        lookup_line_addr = 27'h100;
        @(negedge clk);
        chk("t3_youngest", lookup_data, mk(32'hD2));
        @(posedge clk); #1;
        lookup_line_addr = 27'h400;
        push_valid = 1'b1; push_line_addr = 27'h400; push_data = mk(32'hDE);
        @(negedge clk);
        chk("t3_same_cycle_push", 256'(lookup_hit), 256'd0);
        @(posedge clk); #1;
        push_valid = 1'b0;
        exp_q.push_back({27'h400, 5'd0, mk(32'hDE)});
        chk("t3_next_cycle_visible", lookup_data, mk(32'hDE));
        lookup_line_addr = 27'h100;
        ack();
        @(negedge clk);
        chk("t3_after_pop_hit", lookup_data, mk(32'hD2));
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        repeat (3) ack();
        repeat (3) @(posedge clk); #1;

        // 4: push and pop in the same cycle at count 3, GAP between writes
        push(27'h500, mk(32'hF0));
        push(27'h501, mk(32'hF1));
        push(27'h502, mk(32'hF2));
        wait_write();
        @(posedge clk); #1;
        mem_resp = 1'b1;
        push_valid = 1'b1; push_line_addr = 27'h503; push_data = mk(32'hF3);
        @(negedge clk);
        chk("t4_pre_count", 256'(count), 256'd3);
        chk("t4_pre_ready", 256'(push_ready), 256'd1);
        @(posedge clk); #1;
        mem_resp = 1'b0; push_valid = 1'b0;
        exp_q.push_back({27'h503, 5'd0, mk(32'hF3)});
        @(negedge clk);
        chk("t4_count_kept", 256'(count), 256'd3);
        chk("t4_gap", 256'(mem_write), 256'd0);
        @(negedge clk);
        chk("t4_next_write", 256'(mem_write), 256'd1);
        chk("t4_next_addr", 256'(mem_addr), 256'h0000_A020);
        @(posedge clk); #1;
        repeat (3) ack();
        repeat (3) @(posedge clk); #1;

        // 5: reset in the middle of a write drops everything immediately
        push(27'h600, mk(32'hE0));
        push(27'h601, mk(32'hE1));
        push(27'h602, mk(32'hE2));
        wait_write();
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_write", 256'(mem_write), 256'd0);
        chk("t5_rst_count", 256'(count), 256'd0);
        chk("t5_rst_empty", 256'(empty), 256'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t5_no_write", 256'(mem_write), 256'd0);
        end
        @(posedge clk); #1;
        push(27'h7, mk(32'hC7));
        ack();
        repeat (3) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_writes: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
